// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the shared-ALU arbiter:
// opcodes, modes, grant encodings, FSM states and SA opcode helper.
package alu_share_arbiter_pkg;

  localparam logic [2:0] ALU_MULTIPLY = 3'b100;
  localparam logic [2:0] ALU_DIVISION = 3'b010;
  localparam logic [2:0] ALU_SQRTPOWS = 3'b001;

  localparam logic [1:0] MULTI_PURE = 2'b00;
  localparam logic [1:0] MULTI_FRAC = 2'b01;
  localparam logic [1:0] MULTI_MAXM = 2'b10;
  localparam logic [1:0] SA_DIV     = 2'b11;

  // SA transactions always run in plain mode
  localparam logic [1:0] SA_MODE = MULTI_PURE;

  localparam logic [1:0] GNT_CPU = 2'b01;
  localparam logic [1:0] GNT_SA  = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RUN  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [2:0] typ;
    logic [1:0] mode;
  } alu_op_t;

  // multiply wins if both SA request lines are high
  function automatic logic [2:0] sa_opcode(
    input logic i_mul,
    input logic i_div
  );
    if (i_mul)      return ALU_MULTIPLY;
    else if (i_div) return ALU_DIVISION;
    else            return 3'b000;
  endfunction

endpackage

// File: rtl/alu_arb_grant.sv
// Grant logic: one-hot grant (bit0 CPU, bit1 SA) from two request levels.
// ALU_ARB_RR_EN: round-robin on collision with a last-grant register
// (ports i_clk/i_rst/i_upd exist only then); otherwise fixed SA priority.
module alu_arb_grant
  import alu_share_arbiter_pkg::*;
(
`ifdef ALU_ARB_RR_EN
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_upd,
`endif
  input  logic       i_cpu_req,
  input  logic       i_sa_req,
  output logic [1:0] o_gnt
);

  logic w_sa_first;

`ifdef ALU_ARB_RR_EN
  // 1 = SA was granted last; reset treats CPU as last
  logic r_last_sa;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last_sa <= 1'b0;
    end else if (i_upd) begin
      r_last_sa <= o_gnt[1];
    end
  end

  assign w_sa_first = ~r_last_sa;
`else
  assign w_sa_first = 1'b1;
`endif

  always_comb begin
    o_gnt = '0;
    unique case ({i_sa_req, i_cpu_req})
      2'b11:   o_gnt = w_sa_first ? GNT_SA : GNT_CPU;
      2'b10:   o_gnt = GNT_SA;
      2'b01:   o_gnt = GNT_CPU;
      default: o_gnt = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shared mul/div/sqrt ALU arbiter between CPU (req 0) and SA (req 1).
// Ports: CPU_*/SA_* requester sides, ALU_* ALU side, F_RES/P_RES/ERR
// results. Macro ALU_ARB_RR_EN selects round-robin arbitration.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int OPND_WIDTH     = 13,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_WIDTH       = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CPU_REQ,
  input  logic [2:0]            CPU_TYPE,
  input  logic [1:0]            CPU_MODE,
  input  logic [OPND_WIDTH-1:0] CPU_X,
  input  logic [OPND_WIDTH-1:0] CPU_Y,
  output logic                  CPU_DONE,
  input  logic                  SA_MUL_REQ,
  input  logic                  SA_DIV_REQ,
  input  logic [OPND_WIDTH-1:0] SA_X,
  input  logic [OPND_WIDTH-1:0] SA_Y,
  output logic                  SA_DONE,
  output logic [OPND_WIDTH-1:0] F_RES,
  output logic [OPND_WIDTH-1:0] P_RES,
  output logic                  ERR,
  output logic                  ALU_START,
  output logic [2:0]            ALU_TYPE,
  output logic [1:0]            ALU_MODE,
  output logic [OPND_WIDTH-1:0] ALU_X,
  output logic [OPND_WIDTH-1:0] ALU_Y,
  input  logic [OPND_WIDTH-1:0] ALU_FOUT,
  input  logic [OPND_WIDTH-1:0] ALU_POUT,
  input  logic                  ALU_DONE
);

  localparam logic [TO_WIDTH-1:0] TO_LAST =
    TO_WIDTH'(TIMEOUT_CYCLES - 1);

  arb_state_t            r_state;
  logic                  r_owner;
  logic [TO_WIDTH-1:0]   r_wd;
  alu_op_t               r_op;
  logic [OPND_WIDTH-1:0] r_x;
  logic [OPND_WIDTH-1:0] r_y;
  logic                  r_start;
  logic                  r_cpu_done;
  logic                  r_sa_done;
  logic [OPND_WIDTH-1:0] r_f;
  logic [OPND_WIDTH-1:0] r_p;
  logic                  r_err;

  logic                  w_cpu;
  logic                  w_sa;
  logic [1:0]            w_gnt;
  logic                  w_own_req;
  logic                  w_alu_ok;
  logic                  w_to;

  assign w_cpu = CPU_REQ;
  assign w_sa  = SA_MUL_REQ | SA_DIV_REQ;

`ifdef ALU_ARB_RR_EN
  logic w_gnt_en;
  assign w_gnt_en = (r_state == ARB_IDLE) & (w_cpu | w_sa);
`endif

  alu_arb_grant u_grant (
`ifdef ALU_ARB_RR_EN
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_upd     (w_gnt_en),
`endif
    .i_cpu_req (w_cpu),
    .i_sa_req  (w_sa),
    .o_gnt     (w_gnt)
  );

  assign w_own_req = r_owner ? w_sa : w_cpu;
  // ALU_DONE only counts once START is actually on the wire
  assign w_alu_ok  = r_start & ALU_DONE;
  assign w_to      = (r_wd == TO_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ARB_IDLE;
      r_owner    <= 1'b0;
      r_wd       <= '0;
      r_op       <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_start    <= 1'b0;
      r_cpu_done <= 1'b0;
      r_sa_done  <= 1'b0;
      r_f        <= '0;
      r_p        <= '0;
      r_err      <= 1'b0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          unique case (1'b1)
            w_gnt[1]: begin
              r_owner   <= 1'b1;
              r_x       <= SA_X;
              r_y       <= SA_Y;
              r_op.typ  <= sa_opcode(SA_MUL_REQ, SA_DIV_REQ);
              r_op.mode <= SA_MODE;
            end
            w_gnt[0]: begin
              r_owner   <= 1'b0;
              r_x       <= CPU_X;
              r_y       <= CPU_Y;
              r_op.typ  <= CPU_TYPE;
              r_op.mode <= CPU_MODE;
            end
            default: ;
          endcase
          if (|w_gnt) begin
            r_wd    <= '0;
            r_state <= ARB_RUN;
          end
        end
        ARB_RUN: begin
          r_wd <= r_wd + 1'b1;
          if (w_alu_ok || w_to) begin
            r_start    <= 1'b0;
            r_cpu_done <= ~r_owner;
            r_sa_done  <= r_owner;
            r_state    <= ARB_RESP;
            if (w_alu_ok) begin
              r_f <= ALU_FOUT;
              r_p <= ALU_POUT;
            end else begin
              r_err <= 1'b1;
              r_f   <= '0;
              r_p   <= '0;
            end
          end else begin
            r_start <= 1'b1;
          end
        end
        ARB_RESP: begin
          if (!w_own_req) begin
            r_cpu_done <= 1'b0;
            r_sa_done  <= 1'b0;
            r_wd       <= '0;
            r_state    <= ARB_IDLE;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign CPU_DONE  = r_cpu_done;
  assign SA_DONE   = r_sa_done;
  assign F_RES     = r_f;
  assign P_RES     = r_p;
  assign ERR       = r_err;
  assign ALU_START = r_start;
  assign ALU_TYPE  = r_op.typ;
  assign ALU_MODE  = r_op.mode;
  assign ALU_X     = r_x;
  assign ALU_Y     = r_y;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU model.
// Vector table plus hand-written collision/timeout/reset sequences.
module tb_alu_share_arbiter;

  localparam int W   = 13;
  localparam int LAT = 6;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         CPU_REQ = 1'b0;
  logic [2:0]   CPU_TYPE = '0;
  logic [1:0]   CPU_MODE = '0;
  logic [W-1:0] CPU_X = '0;
  logic [W-1:0] CPU_Y = '0;
  logic         CPU_DONE;
  logic         SA_MUL_REQ = 1'b0;
  logic         SA_DIV_REQ = 1'b0;
  logic [W-1:0] SA_X = '0;
  logic [W-1:0] SA_Y = '0;
  logic         SA_DONE;
  logic [W-1:0] F_RES;
  logic [W-1:0] P_RES;
  logic         ERR;
  logic         ALU_START;
  logic [2:0]   ALU_TYPE;
  logic [1:0]   ALU_MODE;
  logic [W-1:0] ALU_X;
  logic [W-1:0] ALU_Y;
  logic [W-1:0] ALU_FOUT = '0;
  logic [W-1:0] ALU_POUT = '0;
  logic         ALU_DONE = 1'b0;

  alu_share_arbiter #(
    .OPND_WIDTH     (W),
    .TIMEOUT_CYCLES (20),
    .TO_WIDTH       (10)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .CPU_REQ    (CPU_REQ),
    .CPU_TYPE   (CPU_TYPE),
    .CPU_MODE   (CPU_MODE),
    .CPU_X      (CPU_X),
    .CPU_Y      (CPU_Y),
    .CPU_DONE   (CPU_DONE),
    .SA_MUL_REQ (SA_MUL_REQ),
    .SA_DIV_REQ (SA_DIV_REQ),
    .SA_X       (SA_X),
    .SA_Y       (SA_Y),
    .SA_DONE    (SA_DONE),
    .F_RES      (F_RES),
    .P_RES      (P_RES),
    .ERR        (ERR),
    .ALU_START  (ALU_START),
    .ALU_TYPE   (ALU_TYPE),
    .ALU_MODE   (ALU_MODE),
    .ALU_X      (ALU_X),
    .ALU_Y      (ALU_Y),
    .ALU_FOUT   (ALU_FOUT),
    .ALU_POUT   (ALU_POUT),
    .ALU_DONE   (ALU_DONE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit hang = 1'b0;
  int acnt = 0;
  logic [2*W-1:0] prod;

  // ALU model: DONE rises LAT cycles after the first START cycle
  always @(negedge CLK) begin
    if (!ALU_START) begin
      acnt = 0;
      ALU_DONE = 1'b0;
    end else begin
      acnt = acnt + 1;
      if (acnt > LAT && !hang) begin
        ALU_DONE = 1'b1;
        case (ALU_TYPE)
          3'b100: begin
            prod = ALU_X * ALU_Y;
            ALU_FOUT = prod[W-1:0];
            ALU_POUT = prod[2*W-1:W];
          end
          3'b010: begin
            ALU_FOUT = (ALU_Y != 0) ? ALU_X / ALU_Y : '0;
            ALU_POUT = (ALU_Y != 0) ? ALU_X % ALU_Y : '0;
          end
          3'b001: begin
            ALU_FOUT = ALU_X + ALU_Y;
            ALU_POUT = ALU_X - ALU_Y;
          end
          default: begin
            ALU_FOUT = '0;
            ALU_POUT = '0;
          end
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!(CPU_DONE || SA_DONE) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (!(CPU_DONE || SA_DONE)) begin
      errors++;
      $display("FAIL %s: no DONE after %0d cycles, expected 1", nm, n);
    end
  endtask

  task automatic drop_all();
    CPU_REQ = 1'b0;
    SA_MUL_REQ = 1'b0;
    SA_DIV_REQ = 1'b0;
  endtask

  typedef struct {
    bit           sa;
    logic [2:0]   typ;
    logic [1:0]   mode;
    bit           mul;
    bit           dv;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [2:0]   etyp;
    logic [1:0]   emode;
    logic [W-1:0] ef;
    logic [W-1:0] ep;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit sa, input int typ, input int mode,
                     input bit mul, input bit dv, input int x,
                     input int y, input int etyp, input int emode,
                     input int ef, input int ep);
    vec_t t;
    t.sa = sa;
    t.typ = 3'(typ);
    t.mode = 2'(mode);
    t.mul = mul;
    t.dv = dv;
    t.x = W'(x);
    t.y = W'(y);
    t.etyp = 3'(etyp);
    t.emode = 2'(emode);
    t.ef = W'(ef);
    t.ep = W'(ep);
    vq.push_back(t);
  endtask

  vec_t t;
  bit rr_exp[3];

  initial begin
    add(0, 3'b100, 1, 0, 0, 9, 5, 3'b100, 1, 45, 0);
    add(0, 3'b010, 2, 0, 0, 100, 7, 3'b010, 2, 14, 2);
    add(0, 3'b001, 3, 0, 0, 30, 12, 3'b001, 3, 42, 18);
    add(1, 0, 0, 1, 0, 100, 100, 3'b100, 0, 1808, 1);
    add(1, 0, 0, 0, 1, 50, 8, 3'b010, 0, 6, 2);
    add(1, 0, 0, 1, 1, 7, 6, 3'b100, 0, 42, 0);
    add(0, 3'b100, 0, 0, 0, 8191, 1, 3'b100, 0, 8191, 0);
    add(0, 3'b100, 0, 0, 0, 8191, 8191, 3'b100, 0, 1, 8190);

`ifdef ALU_ARB_RR_EN
    rr_exp = '{1'b1, 1'b0, 1'b1};
`else
    rr_exp = '{1'b1, 1'b1, 1'b1};
`endif

    // reset state
    repeat (2) @(negedge CLK);
    chk("rst_cpu_done", CPU_DONE, 0);
    chk("rst_sa_done", SA_DONE, 0);
    chk("rst_start", ALU_START, 0);
    chk("rst_err", ERR, 0);
    chk("rst_f", F_RES, 0);
    chk("rst_type", ALU_TYPE, 0);
    RST = 1'b0;
    @(negedge CLK);

    // CPU only, exact latency
    CPU_REQ = 1'b1;
    CPU_TYPE = 3'b100;
    CPU_MODE = 2'b00;
    CPU_X = 9;
    CPU_Y = 5;
    @(negedge CLK);
    chk("lat_start_c1", ALU_START, 0);
    @(negedge CLK);
    chk("lat_start_c2", ALU_START, 1);
    repeat (6) @(negedge CLK);
    chk("lat_done_c8", CPU_DONE, 0);
    @(negedge CLK);
    chk("lat_done_c9", CPU_DONE, 1);
    chk("lat_f", F_RES, 45);
    chk("lat_sa_done", SA_DONE, 0);
    chk("lat_start_off", ALU_START, 0);
    CPU_REQ = 1'b0;
    @(negedge CLK);
    chk("lat_done_drop", CPU_DONE, 0);

    // vector table
    foreach (vq[i]) begin
      t = vq[i];
      @(negedge CLK);
      if (t.sa) begin
        SA_MUL_REQ = t.mul;
        SA_DIV_REQ = t.dv;
        SA_X = t.x;
        SA_Y = t.y;
      end else begin
        CPU_REQ = 1'b1;
        CPU_TYPE = t.typ;
        CPU_MODE = t.mode;
        CPU_X = t.x;
        CPU_Y = t.y;
      end
      repeat (2) @(negedge CLK);
      chk($sformatf("v%0d_start", i), ALU_START, 1);
      chk($sformatf("v%0d_type", i), ALU_TYPE, t.etyp);
      chk($sformatf("v%0d_mode", i), ALU_MODE, t.emode);
      chk($sformatf("v%0d_x", i), ALU_X, t.x);
      chk($sformatf("v%0d_y", i), ALU_Y, t.y);
      CPU_X = 13'h1555;
      SA_X = 13'h0aaa;
      @(negedge CLK);
      chk($sformatf("v%0d_x_hold", i), ALU_X, t.x);
      wait_done($sformatf("v%0d_wait", i));
      chk($sformatf("v%0d_cpu_done", i), CPU_DONE, !t.sa);
      chk($sformatf("v%0d_sa_done", i), SA_DONE, t.sa);
      chk($sformatf("v%0d_f", i), F_RES, t.ef);
      chk($sformatf("v%0d_p", i), P_RES, t.ep);
      drop_all();
      @(negedge CLK);
      chk($sformatf("v%0d_clr", i), CPU_DONE | SA_DONE, 0);
    end

    // collision: SA first, CPU pending
    @(negedge CLK);
    CPU_REQ = 1'b1;
    CPU_TYPE = 3'b100;
    CPU_MODE = 2'b01;
    CPU_X = 3;
    CPU_Y = 4;
    SA_DIV_REQ = 1'b1;
    SA_X = 20;
    SA_Y = 5;
    repeat (2) @(negedge CLK);
    chk("col_sa_type", ALU_TYPE, 3'b010);
    chk("col_sa_mode", ALU_MODE, 0);
    chk("col_sa_x", ALU_X, 20);
    wait_done("col_sa_wait");
    chk("col_sa_done", SA_DONE, 1);
    chk("col_cpu_idle", CPU_DONE, 0);
    chk("col_sa_f", F_RES, 4);
    SA_DIV_REQ = 1'b0;
    @(negedge CLK);
    chk("col_gap", CPU_DONE | SA_DONE, 0);
    wait_done("col_cpu_wait");
    chk("col_cpu_done", CPU_DONE, 1);
    chk("col_cpu_sa0", SA_DONE, 0);
    chk("col_cpu_type", ALU_TYPE, 3'b100);
    chk("col_cpu_mode", ALU_MODE, 1);
    chk("col_cpu_f", F_RES, 12);
    drop_all();
    @(negedge CLK);

    // three back-to-back collisions
    for (int r = 0; r < 3; r++) begin
      @(negedge CLK);
      CPU_REQ = 1'b1;
      CPU_TYPE = 3'b100;
      CPU_MODE = 2'b00;
      CPU_X = 2;
      CPU_Y = 3;
      SA_DIV_REQ = 1'b1;
      SA_X = 9;
      SA_Y = 3;
      repeat (2) @(negedge CLK);
      chk($sformatf("rr%0d_type", r), ALU_TYPE,
          rr_exp[r] ? 3'b010 : 3'b100);
      wait_done($sformatf("rr%0d_wait", r));
      chk($sformatf("rr%0d_sa", r), SA_DONE, rr_exp[r]);
      chk($sformatf("rr%0d_cpu", r), CPU_DONE, !rr_exp[r]);
      chk($sformatf("rr%0d_f", r), F_RES, rr_exp[r] ? 3 : 6);
      drop_all();
      repeat (2) @(negedge CLK);
    end

    // watchdog timeout
    hang = 1'b1;
    CPU_REQ = 1'b1;
    CPU_TYPE = 3'b100;
    CPU_X = 3;
    CPU_Y = 3;
    repeat (20) @(negedge CLK);
    chk("to_done_c20", CPU_DONE, 0);
    chk("to_err_c20", ERR, 0);
    @(negedge CLK);
    chk("to_done_c21", CPU_DONE, 1);
    chk("to_err", ERR, 1);
    chk("to_f", F_RES, 0);
    chk("to_p", P_RES, 0);
    chk("to_start", ALU_START, 0);
    drop_all();
    hang = 1'b0;
    @(negedge CLK);
    CPU_REQ = 1'b1;
    CPU_X = 4;
    CPU_Y = 5;
    wait_done("to_good_wait");
    chk("to_good_f", F_RES, 20);
    chk("to_err_sticky", ERR, 1);
    drop_all();
    @(negedge CLK);

    // reset during RUN, request stays up
    @(negedge CLK);
    CPU_REQ = 1'b1;
    CPU_TYPE = 3'b010;
    CPU_X = 40;
    CPU_Y = 5;
    repeat (4) @(negedge CLK);
    chk("rr_run_start", ALU_START, 1);
    RST = 1'b1;
    #1;
    chk("rs_start", ALU_START, 0);
    chk("rs_done", CPU_DONE, 0);
    chk("rs_err", ERR, 0);
    chk("rs_f", F_RES, 0);
    chk("rs_x", ALU_X, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rs_restart", ALU_START, 1);
    chk("rs_restart_x", ALU_X, 40);
    wait_done("rs_wait");
    chk("rs_cpu_done", CPU_DONE, 1);
    chk("rs_res_f", F_RES, 8);
    drop_all();
    @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
